// File: rtl/pipe_id_tracker.sv
// Tags every fetched instruction with a wrapping sequence ID and tracks it through F/D/X/M/W.
// Define PIPE_ID_STALL_CNT_EN to build the per-stage stall counters that feed wb_stall_cnt.
module pipe_id_tracker #(
    parameter int ID_W    = 7,
    parameter int STALL_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    output logic [ID_W-1:0]    fetch_id,
    output logic [ID_W-1:0]    decode_id,
    output logic [ID_W-1:0]    execute_id,
    output logic [ID_W-1:0]    memory_id,
    output logic [ID_W-1:0]    wb_id,
    output logic               decode_valid,
    output logic               execute_valid,
    output logic               memory_valid,
    output logic               wb_valid,
    output logic [STALL_W-1:0] wb_stall_cnt,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt,
    output logic [CNT_W-1:0]   squashed_cnt
);

    // Stage index: 0=F, 1=D, 2=X, 3=M, 4=W. The F id doubles as next_id.
    localparam int STAGES = 4;

    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][ID_W-1:0] id_pipe;

    // Negedge so the CPU's posedge-updated stall/flush are sampled mid-cycle.
    always_ff @(negedge clk) begin
        if (rst) begin
            vld_pipe     <= {{STAGES{1'b0}}, 1'b1};
            id_pipe      <= '0;
            retired_cnt  <= '0;
            squashed_cnt <= '0;
        end else begin
            if (vld_pipe[STAGES])
                retired_cnt <= retired_cnt + CNT_W'(1);
            vld_pipe[4:3] <= vld_pipe[3:2];
            id_pipe[4:3]  <= id_pipe[3:2];
            if (stall) begin
                // F and D hold; flush is ignored until the stall clears.
                vld_pipe[2] <= 1'b0;
                id_pipe[2]  <= '0;
            end else begin
                vld_pipe[0] <= 1'b1;
                id_pipe[0]  <= id_pipe[0] + ID_W'(1);
                vld_pipe[1] <= vld_pipe[0] & ~flush;
                id_pipe[1]  <= flush ? '0 : id_pipe[0];
                vld_pipe[2] <= vld_pipe[1];
                id_pipe[2]  <= id_pipe[1];
                if (flush)
                    squashed_cnt <= squashed_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PIPE_ID_STALL_CNT_EN
    logic [STAGES:0][STALL_W-1:0] sc_pipe;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    always_ff @(negedge clk) begin
        if (rst) begin
            sc_pipe <= '0;
        end else begin
            sc_pipe[4:3] <= sc_pipe[3:2];
            if (stall) begin
                if (vld_pipe[0]) sc_pipe[0] <= sat_inc(sc_pipe[0]);
                if (vld_pipe[1]) sc_pipe[1] <= sat_inc(sc_pipe[1]);
                sc_pipe[2] <= '0;
            end else begin
                sc_pipe[0] <= '0;
                sc_pipe[1] <= flush ? '0 : sc_pipe[0];
                sc_pipe[2] <= sc_pipe[1];
            end
        end
    end

    assign wb_stall_cnt = sc_pipe[STAGES];
`else
    assign wb_stall_cnt = '0;
`endif

    assign fetch_id      = id_pipe[0];
    assign decode_id     = id_pipe[1];
    assign execute_id    = id_pipe[2];
    assign memory_id     = id_pipe[3];
    assign wb_id         = id_pipe[4];
    assign decode_valid  = vld_pipe[1];
    assign execute_valid = vld_pipe[2];
    assign memory_valid  = vld_pipe[3];
    assign wb_valid      = vld_pipe[4];
    assign retire        = vld_pipe[4];

endmodule

// File: doc/pipe_id_tracker.md
Name: pipe_id_tracker

Overview:
- Synthesizable instruction-tag tracker that runs beside the 5-stage CPU pipeline (F, D, X, M, W).
- Assigns a sequence ID to each fetched instruction and carries {valid, id, stall_cnt} through the pipeline, mirroring CPU stall and flush.
- Produces per-stage ID/valid and a W-stage retire pulse. These outputs feed the downstream pipeline-trace/verification unit, which indexes its message store by them.
- Also keeps retire and squash counters.

Parameters:
- ID_W, 7: width of the instruction sequence ID. Wraps modulo 2^ID_W.
- STALL_W, 3: width of the per-instruction stall counter. Saturates.
- CNT_W, 16: width of the retired and squashed counters. Wraps.

Ports:
- clk  in  1  system clock. All state updates on negedge clk, so the CPU's posedge-updated pipeline signals are sampled mid-cycle.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  CPU hazard stall. Holds F and D and inserts a bubble into X.
- flush  in  1  CPU IF/ID flush (taken branch resolved in D). Squashes the F-stage instruction.
- fetch_id  out  ID_W  ID of the instruction currently in F.
- decode_id, execute_id, memory_id, wb_id  out  ID_W each  per-stage IDs.
- decode_valid, execute_valid, memory_valid, wb_valid  out  1 each  stage holds a real instruction.
- wb_stall_cnt  out  STALL_W  total stall cycles accumulated by the W-stage instruction.
- retire  out  1  one-cycle pulse; equals wb_valid.
- retired_cnt  out  CNT_W  number of instructions retired.
- squashed_cnt  out  CNT_W  number of instructions flushed.

Behaviour:
- Reset (rst=1 at negedge):
  - next_id=0.
  - F entry = {valid=1, id=0, stall_cnt=0}.
  - D, X, M, W valid=0, id=0, stall_cnt=0.
  - retired_cnt=0, squashed_cnt=0.
  - All outputs are 0 except fetch_id=0, which is still a real value.
  - Reset mid-operation discards all in-flight entries; there is no partial retire.
- F is always valid after reset, because the PC always fetches.
- Normal advance (stall=0, flush=0):
  - D<=F, X<=D, M<=X, W<=M.
  - next_id<=next_id+1 (wraps). F<={1, next_id+1, 0}.
- Stall (stall=1):
  - F and D hold their id and valid.
  - F.stall_cnt and D.stall_cnt increment (if valid), saturating at 2^STALL_W-1.
  - X<=bubble (valid=0). M<=X, W<=M.
  - next_id holds.
- Flush (flush=1, stall=0):
  - D<=bubble. The F instruction's ID is consumed and never reused.
  - squashed_cnt increments.
  - X<=D, M<=X, W<=M. next_id and F advance exactly as in normal advance.
- Stall and flush together: stall has priority. Flush is ignored that cycle; the CPU must hold flush until the stall clears.
- A stall_cnt accumulated in F or D travels with the instruction to W.
- retired_cnt increments on each negedge where W.valid=1 (counting the entry present before the update).
- Latency: an ID assigned in F reaches W after 4 non-stalled advances, i.e. 4 cycles plus the number of stall cycles it saw.
- ID wrap:
  - With ID_W=7, ID 127 is followed by 0.
  - At most 5 IDs are in flight, so no aliasing occurs for ID_W>=3.
  - Consumers must size their stores to 2^ID_W entries.
- Counter wrap: retired_cnt and squashed_cnt wrap silently at 2^CNT_W.

Optional Feature:
- Macro: PIPE_ID_STALL_CNT_EN.
- Defined: stall_cnt fields exist in every stage and wb_stall_cnt reports them as described above.
- Undefined: no stall_cnt storage is built and wb_stall_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then 10 cycles with stall=0, flush=0:
  - wb_valid first rises on the 4th negedge after reset deasserts, with wb_id=0.
  - wb_id then increments 1,2,3...
  - retired_cnt=6 after 10 cycles.
- Stall for 2 cycles while ID 3 is in D:
  - ID 3 reaches W 2 cycles late, with wb_stall_cnt=2.
  - Exactly two bubbles (wb_valid=0) appear in W ahead of it.
  - ID 4 (held in F) also retires with wb_stall_cnt=2.
- Flush pulse while ID 5 is in F:
  - ID 5 never appears at W, and a bubble replaces it.
  - Next retire after ID 4 is ID 6.
  - squashed_cnt=1.
- stall=1 and flush=1 in the same cycle:
  - Flush is ignored and squashed_cnt is unchanged.
  - Flush then re-asserted with stall=0 squashes the F instruction.
- Run 140 instructions with ID_W=7: wb_id sequence passes 126,127,0,1 with no gap.
- Assert rst for one cycle with 4 instructions in flight: all valids are 0 and both counters are 0 on the next negedge; F id=0.
